// File: rtl/program_loader_pkg.sv
// Shared loader definitions: state encodings, code-segment base address, address helper.
// The macros below are the single source of these literals for every file in the loader.
`ifndef PROGRAM_LOADER_DEFS_SVH
`define PROGRAM_LOADER_DEFS_SVH
`define CODE_SEG_PC  32'h0000_3000
`define PL_ST_IDLE   3'd0
`define PL_ST_LEN_HI 3'd1
`define PL_ST_LEN_LO 3'd2
`define PL_ST_DATA   3'd3
`define PL_ST_CSUM   3'd4
`define PL_ST_RUN    3'd5
`define PL_ST_ERR    3'd6
`endif

package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = `PL_ST_IDLE,
        ST_LEN_HI = `PL_ST_LEN_HI,
        ST_LEN_LO = `PL_ST_LEN_LO,
        ST_DATA   = `PL_ST_DATA,
        ST_CSUM   = `PL_ST_CSUM,
        ST_RUN    = `PL_ST_RUN,
        ST_ERR    = `PL_ST_ERR
    } state_t;

    localparam logic [31:0] CODE_SEG_PC = `CODE_SEG_PC;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word; word_ready pulses the cycle after the 4th byte.
// No backpressure of its own: it takes a byte whenever byte_vld is high.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic        word_ready,
    output logic        last_byte
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        ready_q, ready_d;

    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        ready_d = 1'b0;
        if (clr) begin
            cnt_d  = 2'd0;
            word_d = 32'd0;
        end else if (byte_vld) begin
            word_d  = {word_q[23:0], byte_dat};
            cnt_d   = cnt_q + 2'd1;
            ready_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= 2'd0;
            word_q  <= 32'd0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ready_q <= ready_d;
        end
    end

    assign word_dat   = word_q;
    assign word_ready = ready_q;
    assign last_byte  = (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory, then releases the CPU.
// One word write per 4 payload bytes, issued the cycle after the 4th byte; in_ready depends only on state.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = `CODE_SEG_PC,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  acc_q, acc_d;
    logic [15:0] n_rx;
    logic        fire, pack_vld, pack_clr, word_ready, last_byte;
    logic [31:0] word_dat;

    assign in_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign fire     = in_valid && in_ready;
    assign pack_vld = fire && (state_q == ST_DATA);
    assign n_rx     = {len_hi_q, in_data};

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        pack_clr = 1'b0;
        // The write pulse trails the 4th byte, so the index advances while the address is being used.
        if (word_ready) idx_d = idx_q + 16'd1;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (fire) begin
                    len_hi_d = in_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (fire) begin
                    len_d = n_rx;
                    if (n_rx == 16'd0 || {1'b0, n_rx} > MAX_N) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d  = ST_DATA;
                        idx_d    = 16'd0;
                        acc_d    = 8'd0;
                        pack_clr = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    acc_d = acc_q ^ in_data;
                    if (last_byte && idx_q == len_q - 16'd1) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (fire) state_d = (in_data == acc_q) ? ST_RUN : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            len_hi_q <= 8'd0;
            len_q    <= 16'd0;
            idx_q    <= 16'd0;
            acc_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
        end
    end

    byte_packer u_byte_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pack_clr),
        .byte_vld   (pack_vld),
        .byte_dat   (in_data),
        .word_dat   (word_dat),
        .word_ready (word_ready),
        .last_byte  (last_byte)
    );

    assign im_we    = word_ready;
    assign im_addr  = word_addr(BASE_ADDR, idx_q);
    assign im_wdata = word_dat;
    assign cpu_rst  = (state_q != ST_RUN);
    assign done     = (state_q == ST_RUN);
    assign err      = (state_q == ST_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized loads against a stream-level reference model of the loader.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready;
    logic [7:0]  in_data;
    logic        im_we, cpu_rst, done, err;
    logic [31:0] im_addr, im_wdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] wq[$];

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(32'h0000_3000), .MAX_WORDS(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            got_addr.push_back(im_addr);
            got_data.push_back(im_wdata);
        end
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // gap: 0 = back-to-back, 1 = one idle cycle before every byte, 2 = random idles with stray start pulses
    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        int waitc;
        g = (gap == 2) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin
            in_valid = 1'b0;
            start    = (gap == 2) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        waitc    = 0;
        while (in_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) check1("in_ready_wait", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic expect_idle_outputs(input string tag, input logic exp_done, input logic exp_err);
        check1({tag, "_cpu_rst"}, cpu_rst, !exp_done);
        check1({tag, "_done"}, done, exp_done);
        check1({tag, "_err"}, err, exp_err);
        check1({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    // Reference: N words at 0x3000 + 4*i in order, unless N is 0 or above 1024;
    // RUN only when the trailing byte equals the XOR of every payload byte.
    task automatic run_load(input logic [15:0] n, input logic [7:0] corrupt, input int gap);
        logic [7:0] x;
        got_addr.delete();
        got_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check1("start_cpu_rst", cpu_rst, 1'b1);
        check1("start_done", done, 1'b0);
        check1("start_err", err, 1'b0);
        check1("start_in_ready", in_ready, 1'b1);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        if (n == 16'd0 || n > 16'd1024) begin
            repeat (2) @(negedge clk);
            expect_idle_outputs("badlen", 1'b0, 1'b1);
            check32("badlen_writes", 32'(got_addr.size()), 32'd0);
            return;
        end
        x = 8'd0;
        for (int w = 0; w < int'(n); w++) begin
            for (int k = 3; k >= 0; k--) begin
                logic [7:0] b;
                b = wq[w][8*k +: 8];
                x = x ^ b;
                send_byte(b, gap);
            end
        end
        send_byte(x ^ corrupt, gap);
        check32("n_writes", 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < got_addr.size() && i < int'(n); i++) begin
            check32("wr_addr", got_addr[i], 32'h0000_3000 + 32'(4 * i));
            check32("wr_data", got_data[i], wq[i]);
        end
        expect_idle_outputs("end", corrupt == 8'd0, corrupt != 8'd0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        expect_idle_outputs("reset", 1'b0, 1'b0);
        check1("reset_im_we", im_we, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        expect_idle_outputs("idle", 1'b0, 1'b0);

        // single addu word, good checksum 0x79
        wq = '{32'h0109_5021};
        run_load(16'd1, 8'h00, 0);

        // start from RUN, two words with in_valid toggling
        wq = '{32'h3C0A_1234, 32'h0800_0C08};
        run_load(16'd2, 8'h00, 1);

        // length rejects
        run_load(16'd0, 8'h00, 0);
        run_load(16'h0401, 8'h00, 0);

        // bad checksum 0x78: word still written, then ERR
        wq = '{32'h0109_5021};
        run_load(16'd1, 8'h01, 0);

        // reset after two payload bytes
        got_addr.delete();
        got_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h09, 0);
        rst = 1'b0;
        @(negedge clk);
        expect_idle_outputs("midrst", 1'b0, 1'b0);
        check1("midrst_im_we", im_we, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check32("midrst_writes", 32'(got_addr.size()), 32'd0);
        wq = '{32'h0109_5021};
        run_load(16'd1, 8'h00, 0);

        // randomized loads with gaps and stray start pulses
        for (int t = 0; t < 8; t++) begin
            int n;
            logic [7:0] corrupt;
            n = int'($urandom_range(1, 6));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            corrupt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_load(16'(n), corrupt, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default `CODE_SEG_PC` (32'h0000_3000): byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 1024: largest accepted word count.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a load.
REQ-006 SHALL have port in_data, input, 8: byte of the load stream.
REQ-007 SHALL have port in_valid, input, 1: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1: the loader accepts the byte; a byte transfers when in_valid and in_ready are both 1.
REQ-009 SHALL have port im_we, output, 1: instruction-memory word write strobe.
REQ-010 SHALL have port im_addr, output, 32: byte address of the word write.
REQ-011 SHALL have port im_wdata, output, 32: word being written.
REQ-012 SHALL have port cpu_rst, output, 1: active-high reset to mips.rst.
REQ-013 SHALL have port done, output, 1: load succeeded and the CPU is released.
REQ-014 SHALL have port err, output, 1: load failed.

Function
REQ-015 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR.
REQ-016 SHALL follow this stream format: N[15:8], N[7:0], then 4N payload bytes, each word big-endian (first byte = bits 31:24), then one checksum byte equal to the XOR of all payload bytes.
REQ-017 SHALL move IDLE/RUN/ERR->LEN_HI on start; start SHALL be ignored in all other states.
REQ-018 SHALL assert in_ready exactly in LEN_HI, LEN_LO, DATA and CSUM, combinationally from state.
REQ-019 SHALL, on the LEN_LO transfer, go to ERR if N==0 or N>MAX_WORDS; otherwise go to DATA with word index=0 and checksum accumulator=0.
REQ-020 SHALL, in DATA, XOR every accepted byte into the accumulator and shift it into the word register.
REQ-021 SHALL, on the 4th byte of a word, pulse im_we for exactly the next cycle with im_addr=BASE_ADDR+4*index and im_wdata=the assembled word; index then increments.
REQ-022 SHALL go DATA->CSUM together with the write of word N-1.
REQ-023 SHALL, on the CSUM transfer, go to RUN if the byte equals the accumulator, else go to ERR.
REQ-024 SHALL hold cpu_rst=1 in every state except RUN; cpu_rst SHALL be 0 from the first cycle in RUN.
REQ-025 SHALL set done=1 only in RUN and err=1 only in ERR.
REQ-026 SHALL hold state and all counters unchanged while in_valid=0 (gaps at any position); no timeout.
REQ-027 SHALL, on a start in RUN or ERR, clear done/err and reassert cpu_rst in the next cycle.
REQ-028 SHALL drive im_we=0 outside the write pulse; im_addr/im_wdata are don't-care while im_we=0.

Reset
REQ-029 SHALL, when rst==0 at a clock edge, set: state=IDLE, cpu_rst=1, im_we=0, in_ready=0, done=0, err=0, index=0, accumulator=0, word register=0.
REQ-030 SHALL, on reset mid-load, abandon the load, drop any partial word, and issue no further writes.

Structure
REQ-031 SHALL put the state encodings (3-bit) and `CODE_SEG_PC` in the shared macro include file; there SHALL be no local literals for them.
REQ-032 SHALL instantiate one sub-module, byte_packer: shift register, 2-bit byte counter and word_ready pulse; FSM, address and checksum stay in program_loader.

Verification
REQ-033 SHALL cover: start; 00 01 01 09 50 21 79 -> one im_we, addr 32'h3000, data 32'h0109_5021; then RUN, cpu_rst=0, done=1; the CPU then executes addu.
REQ-034 SHALL cover: two words 0x3C0A1234, 0x08000C08 with in_valid toggling every other cycle -> writes to 0x3000 and 0x3004 in order; checksum 0x3C^0x0A^0x12^0x34^0x08^0x00^0x0C^0x08 accepted -> RUN.
REQ-035 SHALL cover: length 00 00 -> ERR, err=1, cpu_rst=1, no im_we; the same for length 0x0401 with MAX_WORDS=1024.
REQ-036 SHALL cover: the REQ-033 stream with checksum 0x78 -> the word is still written, then ERR, cpu_rst stays 1.
REQ-037 SHALL cover: rst=0 after 2 payload bytes -> IDLE, outputs at reset values, no write; a fresh load then succeeds.
REQ-038 SHALL cover: start while in RUN -> cpu_rst=1 next cycle, done=0, and a new load overwrites from 0x3000.
